// File: rtl/instruction_mem_if.sv
// Fetch and program-load bus of the writable instruction memory.
// master = CPU fetch stage plus host loader, slave = the memory.
interface instruction_mem_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 28
);
  logic                  iFetchValid;
  logic [ADDR_WIDTH-1:0] iAddress;
  logic                  oFetchReady;
  logic [DATA_WIDTH-1:0] oInstruction;
  logic                  oInstructionValid;
  logic                  oAddrError;
  logic                  iLoadStart;
  logic                  iLoadValid;
  logic [DATA_WIDTH-1:0] iLoadData;
  logic                  iLoadLast;
  logic                  oLoadDone;
  logic [ADDR_WIDTH-1:0] oLoadCount;
  logic                  oBusy;

  modport master (
    output iFetchValid, iAddress,
    output iLoadStart, iLoadValid,
    output iLoadData, iLoadLast,
    input  oFetchReady, oInstruction,
    input  oInstructionValid, oAddrError,
    input  oLoadDone, oLoadCount, oBusy
  );

  modport slave (
    input  iFetchValid, iAddress,
    input  iLoadStart, iLoadValid,
    input  iLoadData, iLoadLast,
    output oFetchReady, oInstruction,
    output oInstructionValid, oAddrError,
    output oLoadDone, oLoadCount, oBusy
  );
endinterface

// File: rtl/instruction_mem.sv
// Writable instruction RAM: cleared after reset, streamed in by a
// host loader, read by the fetch stage with one cycle of latency.
module instruction_mem #(
  parameter int DATA_WIDTH = 28,
  parameter int ADDR_WIDTH = 16,
  parameter int DEPTH      = 256,
  parameter logic [DATA_WIDTH-1:0] DEFAULT_WORD = '0
) (
  input logic              Clock,
  input logic              Reset,
  instruction_mem_if.slave bus
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_X =
    (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST =
    ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_CLEAR,
    S_RUN,
    S_LOAD
  } state_t;

  state_t state;
  state_t nstate;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] ptr;
  logic [ADDR_WIDTH-1:0] load_cnt;
  logic [DATA_WIDTH-1:0] instr;
  logic                  instr_vld;
  logic                  addr_err;
  logic                  load_done;

  logic                  fire;
  logic                  in_range;
  logic                  clr_end;
  logic                  load_wr;
  logic                  load_end;
  logic                  restart;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;

  // A restart inside LOAD takes priority over a word on the same cycle.
  assign fire     = bus.iFetchValid && (state == S_RUN);
  assign in_range = {1'b0, bus.iAddress} < DEPTH_X;
  assign clr_end  = (state == S_CLEAR) && (ptr == LAST);
  assign restart  = bus.iLoadStart && (state != S_CLEAR);
  assign load_wr  = (state == S_LOAD) && bus.iLoadValid
                    && !bus.iLoadStart;
  assign load_end = load_wr && (bus.iLoadLast || ptr == LAST);
  assign wr_en    = (state == S_CLEAR) || load_wr;
  assign wr_data  = (state == S_CLEAR) ? DEFAULT_WORD
                                       : bus.iLoadData;

  assign bus.oFetchReady       = (state == S_RUN);
  assign bus.oBusy             = (state != S_RUN);
  assign bus.oInstruction      = instr;
  assign bus.oInstructionValid = instr_vld;
  assign bus.oAddrError        = addr_err;
  assign bus.oLoadDone         = load_done;
  assign bus.oLoadCount        = load_cnt;

  // State register.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) state <= S_CLEAR;
    else        state <= nstate;
  end

  // Next state: clear sweep, run, and load session.
  always_comb begin
    nstate = state;
    unique case (state)
      S_CLEAR: if (clr_end) nstate = S_RUN;
      S_RUN:   if (bus.iLoadStart) nstate = S_LOAD;
      S_LOAD:  if (load_end) nstate = S_RUN;
      default: nstate = S_CLEAR;
    endcase
  end

  // Shared write pointer for the clear sweep and the load stream.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      ptr <= '0;
    end else if (restart) begin
      ptr <= '0;
    end else if (clr_end) begin
      ptr <= '0;
    end else if (state == S_CLEAR || load_wr) begin
      ptr <= ptr + 1'b1;
    end
  end

  // Words written by the current or most recent load.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      load_cnt <= '0;
    end else if (restart) begin
      load_cnt <= '0;
    end else if (load_wr) begin
      load_cnt <= load_cnt + 1'b1;
    end
  end

  // Single-cycle completion pulse for the loader.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) load_done <= 1'b0;
    else        load_done <= load_end;
  end

  // RAM write port; contents are rebuilt by the clear sweep.
  always_ff @(posedge Clock) begin
    if (wr_en) mem[ptr[IDX_W-1:0]] <= wr_data;
  end

  // Registered fetch response; holds when no fetch is accepted.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      instr     <= DEFAULT_WORD;
      instr_vld <= 1'b0;
      addr_err  <= 1'b0;
    end else begin
      instr_vld <= fire;
      if (fire) begin
        addr_err <= !in_range;
        if (in_range) instr <= mem[bus.iAddress[IDX_W-1:0]];
        else          instr <= DEFAULT_WORD;
      end
    end
  end
endmodule
